// File: rtl/avg_pool_pkg.sv
// Shared types and sizing helpers for the global average pooling stage.
package avg_pool_pkg;

  localparam int DEF_POOL_SIZE    = 49;
  localparam int DEF_NUM_CHANNELS = 8;

  typedef enum logic [1:0] {
    ACCUM,
    DIV_START,
    DIV_RUN,
    OUTPUT
  } state_e;

  // A sum of pool_size values of data_width bits cannot exceed this width.
  function automatic int acc_width(input int data_width, input int pool_size);
    return data_width + $clog2(pool_size);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH iterations,
// done pulses for one cycle alongside the final quotient/remainder.
module seq_udiv #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_next;

  // Trial subtraction of the divisor from the remainder shifted left by one bit.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, div_q});
    rem_next = ge ? WIDTH'(shifted - {1'b0, div_q}) : shifted[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quo_q  <= dividend_i;
        rem_q  <= '0;
        div_q  <= divisor_i;
        cnt_q  <= CNT_W'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= {quo_q[WIDTH-2:0], ge};
        rem_q <= rem_next;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

endmodule

// File: rtl/global_avg_pool.sv
// Global average pooling: sums POOL_SIZE pixels per channel, divides each sum
// by POOL_SIZE and streams one result per channel. AVG_POOL_ROUND_EN selects round-half-up.
module global_avg_pool
  import avg_pool_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int POOL_SIZE    = DEF_POOL_SIZE
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [idx_width(NUM_CHANNELS)-1:0]   out_channel,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, POOL_SIZE);
  localparam int CH_W      = idx_width(NUM_CHANNELS);
  localparam int PIX_W     = idx_width(POOL_SIZE);

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]        out_ch_q, out_ch_d;
  logic [ACC_WIDTH-1:0]   acc_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]        out_channel_q, out_channel_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   in_ready_q, busy_q;

  logic                   div_start, div_done, div_busy;
  logic [ACC_WIDTH-1:0]   div_dividend, div_quotient, div_remainder;

`ifdef AVG_POOL_ROUND_EN
  assign div_dividend = acc_q[out_ch_q] + ACC_WIDTH'(POOL_SIZE / 2);
`else
  assign div_dividend = acc_q[out_ch_q];
`endif

  seq_udiv #(.WIDTH(ACC_WIDTH)) u_div (
    .clock       (clock),
    .reset       (reset),
    .start_i     (div_start),
    .dividend_i  (div_dividend),
    .divisor_i   (ACC_WIDTH'(POOL_SIZE)),
    .quotient_o  (div_quotient),
    .remainder_o (div_remainder),
    .done_o      (div_done),
    .busy_o      (div_busy)
  );

  // The quotient always fits DATA_WIDTH; the upper bits and remainder are unused.
  logic unused_div;
  assign unused_div = ^{div_quotient[ACC_WIDTH-1:DATA_WIDTH], div_remainder, div_busy};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    ch_cnt_d      = ch_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    out_ch_d      = out_ch_q;
    acc_d         = acc_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    div_start     = 1'b0;

    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d[ch_cnt_q] = acc_q[ch_cnt_q] + ACC_WIDTH'(in_data);
          if (ch_cnt_q == CH_W'(NUM_CHANNELS - 1)) begin
            ch_cnt_d = '0;
            if (pix_cnt_q == PIX_W'(POOL_SIZE - 1)) begin
              pix_cnt_d = '0;
              out_ch_d  = '0;
              state_d   = DIV_START;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end
      end
      DIV_START: begin
        div_start = 1'b1;
        state_d   = DIV_RUN;
      end
      DIV_RUN: begin
        if (div_done) begin
          out_data_d    = div_quotient[DATA_WIDTH-1:0];
          out_channel_d = out_ch_q;
          out_valid_d   = 1'b1;
          out_last_d    = (out_ch_q == CH_W'(NUM_CHANNELS - 1));
          state_d       = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_ch_q == CH_W'(NUM_CHANNELS - 1)) begin
            acc_d     = '{default: '0};
            ch_cnt_d  = '0;
            pix_cnt_d = '0;
            state_d   = ACCUM;
          end else begin
            out_ch_d = out_ch_q + CH_W'(1);
            state_d  = DIV_START;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: the accumulator array is reset explicitly because a reset
  // mid-map must discard partial sums, not just the control state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ACCUM;
      ch_cnt_q      <= '0;
      pix_cnt_q     <= '0;
      out_ch_q      <= '0;
      acc_q         <= '{default: '0};
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_cnt_q      <= ch_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      out_ch_q      <= out_ch_d;
      acc_q         <= acc_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      in_ready_q    <= (state_d == ACCUM);
      busy_q        <= (state_d != ACCUM);
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

endmodule

// File: doc/global_avg_pool.md
# global_avg_pool

Parametrised global average pooling stage for the MobileNet head. It accumulates a POOL_SIZE-pixel feature map with NUM_CHANNELS channel-interleaved values per pixel, then divides each channel sum by POOL_SIZE with a sequential divider. It emits one average per channel over a valid/ready stream, and sits between the last pointwise conv layer and the classifier FC layer.

## Interface
- DATA_WIDTH, 32, unsigned input/output element width
- NUM_CHANNELS, 8, channels per pixel, ≥1
- POOL_SIZE, 49, pixels per feature map (7x7), ≥2
- ACC_WIDTH, DATA_WIDTH+$clog2(POOL_SIZE), accumulator/dividend width; derived, not overridden
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- in_data  input  DATA_WIDTH  input element
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts input; beat transfers when in_valid && in_ready
- out_data  output  DATA_WIDTH  channel average
- out_channel  output  $clog2(NUM_CHANNELS) (min 1)  channel index of out_data
- out_valid  output  1  out_data/out_channel valid
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready
- out_last  output  1  high with the channel NUM_CHANNELS-1 result
- busy  output  1  high in any state except ACCUM

## Operation
- Input order is pixel-major: pixel 0 ch0..chC-1, pixel 1 ch0..., and so on. ch_cnt wraps 0..C-1; pix_cnt increments on ch_cnt wrap.
- Accumulator array acc[NUM_CHANNELS], each ACC_WIDTH bits, unsigned. acc[ch_cnt] += in_data per accepted beat. Overflow is impossible by width.
- FSM states: ACCUM, DIV_START, DIV_RUN, OUTPUT.
- ACCUM: in_ready=1. Accepting the last beat (pix_cnt=P-1, ch_cnt=C-1) moves to DIV_START with out_ch=0.
- DIV_START: in_ready=0. Loads the divider with dividend acc[out_ch] and divisor POOL_SIZE, pulses start, then moves to DIV_RUN.
- DIV_RUN: waits for divider done. On done, registers quotient[DATA_WIDTH-1:0] into out_data, registers out_ch into out_channel, sets out_valid, and moves to OUTPUT.
- OUTPUT: holds out_data, out_channel, out_valid and out_last stable while out_ready=0. On handshake:
  - if out_ch=C-1: clear all acc, ch_cnt and pix_cnt; go to ACCUM.
  - otherwise: out_ch++; go to DIV_START.
- Quotient is always < 2^DATA_WIDTH, so truncation to DATA_WIDTH is lossless.
- in_valid outside ACCUM is ignored. No data is lost, because in_ready=0.
- Reset (any time, including mid-division or mid-output): all acc=0, counters=0, state=ACCUM, divider idle. Output reset values: out_valid=0, out_data=0, out_channel=0, out_last=0, busy=0, in_ready=1 once reset deasserts.

## Timing
- Full throughput in ACCUM: one beat per cycle.
- The divider resolves one quotient bit per cycle: ACC_WIDTH iterations.
- Let edge E0 accept the last input beat. Channel 0 out_valid rises after edge E0+ACC_WIDTH+2: DIV_START takes 1 cycle, DIV_RUN takes ACC_WIDTH cycles, capture takes 1.
- Each subsequent channel's out_valid rises ACC_WIDTH+2 cycles after the previous output handshake.
- in_ready returns to 1 in the cycle after the channel C-1 handshake. Accumulators are zero by then.
- in_ready is a registered function of state only. There is no combinational path from out_ready to in_ready or to out_valid.

## Configuration
- AVG_POOL_ROUND_EN defined: dividend = acc[out_ch] + POOL_SIZE/2 (integer), giving round-half-up. The sum fits in ACC_WIDTH.
- AVG_POOL_ROUND_EN undefined: dividend = acc[out_ch], giving truncation (floor).
- Latency is identical in both builds.

## Structure
- Package avg_pool_pkg holds:
  - the FSM state typedef (ACCUM, DIV_START, DIV_RUN, OUTPUT);
  - function acc_width(data_width, pool_size);
  - default constants DEF_POOL_SIZE=49 and DEF_NUM_CHANNELS=8.
- Sub-module seq_udiv, parameter WIDTH: a restoring unsigned divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done (1-cycle pulse after WIDTH iterations), busy.
  - Async reset.

## Test plan
- DATA_WIDTH=8, C=2, P=4, truncation build. Ch0 inputs 1,2,2,2 (sum 7); ch1 inputs 10,10,10,11 (sum 41). Required: out_data 1 (out_channel 0), then 10 (out_channel 1, out_last=1).
- Same stimulus, AVG_POOL_ROUND_EN build. Required: ch0 = 2, ch1 = 10.
- Defaults (32-bit, C=8, P=49), all inputs 0xFFFFFFFF. Required: every channel = 0xFFFFFFFF, and channel 0 out_valid exactly ACC_WIDTH+2=40 cycles after the last accept.
- Backpressure: hold out_ready=0 for 20 cycles on channel 0. Required: out_data and out_channel stable, in_ready=0, no input accepted. Then 2 back-to-back maps give correct independent averages; the second map's accumulation starts from 0.
- Assert reset during DIV_RUN of channel 1. Required:
  - out_valid=0 and in_ready=1 after release;
  - a fresh map with all inputs 5 yields 5 on every channel.
- Random in_valid gaps and random out_ready over 100 maps. Results must match a reference model (floor or rounded, per build), with each map's channel sequence 0..C-1 in order.
